lvds_link_ctrl: RTL and testbench
=================================

Name: lvds_link_ctrl

Overview:
Link sequencer for the 10:1 LVDS transmit lanes. It waits for the serial PLL to report a stable lock, holds the lane serializers in reset, then drives a fixed training word on every lane so the receiver can align. After that it passes live 10-bit pixel words through. It sits in the pixel-clock domain, between the video/encoder pipeline and the per-lane serializers. It owns the lane reset and the lane data mux.

Parameters:
LANES, 4, number of 10-bit lanes controlled
LOCK_CYC, 64, consecutive synchronized-lock cycles required before bring-up (>=1)
RST_CYC, 16, cycles O_lane_rst is held in LANE_RST (>=1)
TRAIN_CYC, 1024, cycles the training word is driven (>=1)
TRAIN_PAT, 10'b1111100000, training word driven on every lane

Ports:
I_pixel_clk  in  1  sole clock, all logic rising-edge
I_rst  in  1  asynchronous, active-high reset
I_pll_lock  in  1  serial PLL lock, asynchronous to I_pixel_clk
I_enable  in  1  link enable, level
I_retrain  in  1  single-cycle request to re-run training from ACTIVE
I_data_in  in  LANES*10  live lane words, lane n at [10n+9:10n]
O_lane_rst  out  1  reset to the lane serializers
O_lane_data  out  LANES*10  words to the serializers
O_link_up  out  1  high only in ACTIVE
O_state  out  2  IDLE=0, LANE_RST=1, TRAIN=2, ACTIVE=3

Behaviour:
- Reset values: state=IDLE, O_lane_rst=1, O_lane_data=0, O_link_up=0, O_state=0, lock synchronizer=0, lock counter=0, phase counter=0.
- Lock path:
  - I_pll_lock passes through a 2-flop synchronizer to give lock_s.
  - A lock counter increments while lock_s=1 and saturates at LOCK_CYC.
  - The lock counter clears on any cycle with lock_s=0.
  - lock_ok = (lock counter == LOCK_CYC).
- Phase counter: clears on every state entry. It is sized as clog2(max(RST_CYC,TRAIN_CYC))+1 bits.
- IDLE:
  - Moves to LANE_RST when lock_ok && I_enable.
- LANE_RST:
  - Stays exactly RST_CYC cycles, then moves to TRAIN.
- TRAIN:
  - Stays exactly TRAIN_CYC cycles, then moves to ACTIVE.
- ACTIVE:
  - A retrain pulse moves the state to TRAIN.
  - Lanes are not reset on retrain.
- Global exits, from any non-IDLE state: lock_s=0 or I_enable=0 moves the state to IDLE on the next edge.
- Priority: lock loss / disable > I_retrain > phase completion.
- I_retrain outside ACTIVE is ignored and is not remembered.
- Decoded outputs, taken straight from the state register with no extra stage:
  - O_lane_rst = 1 in IDLE and LANE_RST.
  - O_link_up = 1 in ACTIVE.
  - O_state = state encoding.
- Data mux: one register stage. At each edge O_lane_data loads a value chosen by the current state:
  - IDLE or LANE_RST: 0.
  - TRAIN: TRAIN_PAT replicated on all lanes.
  - ACTIVE: I_data_in.
- Consequences of that register stage:
  - I_data_in to O_lane_data latency is 1 cycle.
  - O_lane_data lags O_state by one cycle at each transition. For example, the first ACTIVE cycle still outputs TRAIN_PAT.
- Lock-loss timing: lock drop mid-TRAIN or mid-ACTIVE gives O_lane_rst=1 within 3 edges of I_pll_lock falling (2 sync + 1 state). O_lane_data is 0 one edge later.
- Re-bring-up: a fresh lock always requires the full LOCK_CYC qualification again. There is no shortcut.

Test Plan:
All runs use LANES=2, LOCK_CYC=4, RST_CYC=3, TRAIN_CYC=5, TRAIN_PAT=10'b1111100000.
1. Reset: assert I_rst mid-ACTIVE -> immediately state=IDLE, O_lane_rst=1, O_lane_data=0, O_link_up=0.
2. Clean bring-up:
   - Stimulus: I_enable=1; I_pll_lock rises before edge 1; I_data_in=20'h12345.
   - LANE_RST: O_state=1 after edge 7, O_lane_rst=1 through edge 9.
   - TRAIN: O_state=2 after edge 10; O_lane_data=20'hF83E0 after edge 11.
   - ACTIVE: O_state=3 and O_link_up=1 after edge 15; O_lane_data=20'h12345 after edge 16.
3. Lock glitch during qualification: drop I_pll_lock for one cycle after 3 counted cycles -> counter restarts; LANE_RST entry is delayed by the full 4+2 cycles after lock returns.
4. Lock loss in ACTIVE: deassert I_pll_lock -> O_lane_rst=1 and O_state=0 within 3 edges; O_lane_data=0 one edge later; re-lock repeats scenario 2 timing.
5. Retrain: pulse I_retrain in ACTIVE -> next edge O_state=2 with O_lane_rst=0; exactly 5 TRAIN cycles, then ACTIVE. A pulse during TRAIN is ignored, and a pulse coincident with I_enable=0 gives IDLE.
6. Disable: I_enable=0 with lock held in TRAIN -> IDLE next edge. Re-enable -> LANE_RST on the following edge, because lock_ok is still saturated.

Source files
------------

// File: rtl/lvds_link_ctrl.sv
// LVDS transmit link sequencer: PLL lock qualification, lane reset,
// training-word alignment, then live pixel pass-through.
module lvds_link_ctrl #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned LOCK_CYC  = 64,
  parameter int unsigned RST_CYC   = 16,
  parameter int unsigned TRAIN_CYC = 1024,
  parameter logic [9:0]  TRAIN_PAT = 10'b1111100000
) (
  input  logic                  I_pixel_clk,
  input  logic                  I_rst,
  input  logic                  I_pll_lock,
  input  logic                  I_enable,
  input  logic                  I_retrain,
  input  logic [LANES*10-1:0]   I_data_in,
  output logic                  O_lane_rst,
  output logic [LANES*10-1:0]   O_lane_data,
  output logic                  O_link_up,
  output logic [1:0]            O_state
);

  localparam int unsigned DW     = LANES * 10;
  localparam int unsigned LC_W   = $clog2(LOCK_CYC + 1);
  localparam int unsigned PH_MAX = (RST_CYC > TRAIN_CYC) ? RST_CYC : TRAIN_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LANE_RST = 2'd1,
    S_TRAIN    = 2'd2,
    S_ACTIVE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DW-1:0]     lane_data_q, lane_data_d;
  logic              lock_s;
  logic              lock_ok;
  logic              lane_rst_c;
  logic              link_up_c;

  assign lock_s  = sync_q[1];
  assign lock_ok = (lock_cnt_q == LC_W'(LOCK_CYC));

  // State register
  always_ff @(posedge I_pixel_clk or posedge I_rst) begin
    if (I_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; lock loss / disable beats retrain beats phase completion
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && (!lock_s || !I_enable)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (lock_ok && I_enable) state_d = S_LANE_RST;
        S_LANE_RST: if (phase_q == PH_W'(RST_CYC - 1)) state_d = S_TRAIN;
        S_TRAIN:    if (phase_q == PH_W'(TRAIN_CYC - 1)) state_d = S_ACTIVE;
        S_ACTIVE:   if (I_retrain) state_d = S_TRAIN;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Decoded outputs and the next lane word, all from the current state
  always_comb begin
    lane_rst_c  = 1'b0;
    link_up_c   = 1'b0;
    lane_data_d = '0;
    case (state_q)
      S_IDLE, S_LANE_RST: lane_rst_c = 1'b1;
      S_TRAIN:            lane_data_d = {LANES{TRAIN_PAT}};
      S_ACTIVE: begin
        link_up_c   = 1'b1;
        lane_data_d = I_data_in;
      end
      default:            lane_rst_c = 1'b1;
    endcase
  end

  // Lock synchronizer, saturating lock qualifier and per-state phase counter
  always_comb begin
    sync_d     = {sync_q[0], I_pll_lock};
    lock_cnt_d = lock_cnt_q;
    if (!lock_s)       lock_cnt_d = '0;
    else if (!lock_ok) lock_cnt_d = lock_cnt_q + LC_W'(1);
    phase_d = '0;
    if (state_d == state_q && (state_q == S_LANE_RST || state_q == S_TRAIN))
      phase_d = phase_q + PH_W'(1);
  end

  // Datapath and counter registers
  always_ff @(posedge I_pixel_clk or posedge I_rst) begin
    if (I_rst) begin
      sync_q      <= '0;
      lock_cnt_q  <= '0;
      phase_q     <= '0;
      lane_data_q <= '0;
    end else begin
      sync_q      <= sync_d;
      lock_cnt_q  <= lock_cnt_d;
      phase_q     <= phase_d;
      lane_data_q <= lane_data_d;
    end
  end

  assign O_lane_rst  = lane_rst_c;
  assign O_link_up   = link_up_c;
  assign O_state     = state_q;
  assign O_lane_data = lane_data_q;

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Bench for lvds_link_ctrl: directed bring-up scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the link rules.
module tb_lvds_link_ctrl;

  localparam int unsigned LANES     = 2;
  localparam int unsigned LOCK_CYC  = 4;
  localparam int unsigned RST_CYC   = 3;
  localparam int unsigned TRAIN_CYC = 5;
  localparam logic [9:0]  TRAIN_PAT = 10'b1111100000;
  localparam int unsigned DW        = LANES * 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lock = 1'b0;
  logic          en = 1'b0;
  logic          rt = 1'b0;
  logic [DW-1:0] din = '0;
  logic          lane_rst;
  logic [DW-1:0] lane_data;
  logic          link_up;
  logic [1:0]    st;

  int n_run  = 0;
  int n_fail = 0;

  // Model: state name, edges spent in it, consecutive-lock run, lock history
  int            m_st    = 0;
  int            m_dwell = 0;
  int            m_run   = 0;
  bit            m_h0    = 1'b0;
  bit            m_h1    = 1'b0;
  logic [DW-1:0] m_data  = '0;

  lvds_link_ctrl #(
    .LANES(LANES), .LOCK_CYC(LOCK_CYC), .RST_CYC(RST_CYC),
    .TRAIN_CYC(TRAIN_CYC), .TRAIN_PAT(TRAIN_PAT)
  ) dut (
    .I_pixel_clk(clk),
    .I_rst(rst),
    .I_pll_lock(lock),
    .I_enable(en),
    .I_retrain(rt),
    .I_data_in(din),
    .O_lane_rst(lane_rst),
    .O_lane_data(lane_data),
    .O_link_up(link_up),
    .O_state(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_dwell = 0; m_run = 0; m_h0 = 1'b0; m_h1 = 1'b0; m_data = '0;
  endfunction

  // One rising edge of the link rules, using the inputs present at that edge
  function automatic void model_step();
    bit ls  = m_h1;
    bit ok  = (m_run == LOCK_CYC);
    int nst = m_st;
    case (m_st)
      2:       m_data = {LANES{TRAIN_PAT}};
      3:       m_data = din;
      default: m_data = '0;
    endcase
    if (m_st != 0 && (!ls || !en))                 nst = 0;
    else if (m_st == 3 && rt)                      nst = 2;
    else if (m_st == 0 && ok && en)                nst = 1;
    else if (m_st == 1 && m_dwell == RST_CYC)      nst = 2;
    else if (m_st == 2 && m_dwell == TRAIN_CYC)    nst = 3;
    m_dwell = (nst != m_st) ? 1 : m_dwell + 1;
    m_st    = nst;
    m_run   = ls ? ((m_run < LOCK_CYC) ? m_run + 1 : LOCK_CYC) : 0;
    m_h1    = m_h0;
    m_h0    = lock;
  endfunction

  task automatic check_model();
    chk("state",     32'(st),        32'(m_st));
    chk("lane_rst",  32'(lane_rst),  32'(m_st < 2));
    chk("link_up",   32'(link_up),   32'(m_st == 3));
    chk("lane_data", 32'(lane_data), 32'(m_data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // Async reset: outputs must collapse without waiting for an edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_state",    32'(st),        32'd0);
    chk("rst_lane_rst", 32'(lane_rst),  32'd1);
    chk("rst_data",     32'(lane_data), 32'd0);
    chk("rst_link_up",  32'(link_up),   32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic bring_up_checked();
    en = 1'b1; lock = 1'b1; rt = 1'b0; din = 20'h12345;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 6)  chk("bu_idle_e6", 32'(st), 32'd0);
      if (e == 7)  chk("bu_lrst_e7", 32'(st), 32'd1);
      if (e == 9)  chk("bu_lrst_e9", 32'(lane_rst), 32'd1);
      if (e == 10) chk("bu_train_e10", 32'(st), 32'd2);
      if (e == 11) chk("bu_pat_e11", 32'(lane_data), 32'hF83E0);
      if (e == 15) begin
        chk("bu_active_e15", 32'(st), 32'd3);
        chk("bu_linkup_e15", 32'(link_up), 32'd1);
        chk("bu_pat_e15", 32'(lane_data), 32'hF83E0);
      end
      if (e == 16) chk("bu_data_e16", 32'(lane_data), 32'h12345);
    end
  endtask

  initial begin
    #3;
    do_reset();

    // Clean bring-up, then reset mid-ACTIVE
    bring_up_checked();
    do_reset();

    // Lock glitch after three counted cycles restarts qualification
    en = 1'b1; lock = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 3) lock = 1'b0;
      if (e == 4) lock = 1'b1;
      if (e == 10) chk("glitch_idle_e10", 32'(st), 32'd0);
      if (e == 11) chk("glitch_lrst_e11", 32'(st), 32'd1);
    end
    for (int i = 0; i < 10; i++) tick();
    chk("glitch_active", 32'(st), 32'd3);

    // Lock loss in ACTIVE, then full re-qualification
    din = 20'hABCDE;
    lock = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) begin
        chk("loss_state_e3", 32'(st), 32'd0);
        chk("loss_rst_e3", 32'(lane_rst), 32'd1);
      end
      if (e == 4) chk("loss_data_e4", 32'(lane_data), 32'd0);
    end
    bring_up_checked();

    // Retrain from ACTIVE; pulse inside TRAIN is ignored
    rt = 1'b1;
    tick();
    chk("rt_state", 32'(st), 32'd2);
    chk("rt_lane_rst", 32'(lane_rst), 32'd0);
    rt = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rt = (i == 2);
      tick();
      chk("rt_train_len", 32'(st), (i < 5) ? 32'd2 : 32'd3);
    end
    rt = 1'b0;
    tick();

    // Retrain coincident with disable goes to IDLE; re-enable skips requalification
    rt = 1'b1; en = 1'b0;
    tick();
    chk("rt_dis_idle", 32'(st), 32'd0);
    rt = 1'b0; en = 1'b1;
    tick();
    chk("reen_lrst", 32'(st), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("dis_in_train", 32'(st), 32'd2);
    en = 1'b0;
    tick();
    chk("dis_idle", 32'(st), 32'd0);
    en = 1'b1;
    tick();
    chk("dis_reen_lrst", 32'(st), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3)  lock = ~lock;
      if ($urandom_range(0, 199) < 2) en = ~en;
      rt  = ($urandom_range(0, 99) < 5);
      din = DW'($urandom);
      if ($urandom_range(0, 999) < 2) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
